// File: rtl/ifu_idu_buf.sv
// ifu_idu_buf: two-entry registered elastic buffer between fetch and decode.
// Optional macro IFU_IDU_BUF_PERF_EN adds saturating stall/bubble counters.
`default_nettype none

module ifu_idu_buf #(
  parameter int CPU_WIDTH = 32,
  parameter int INS_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pre_valid,
  output logic                 o_pre_ready,
  input  logic [CPU_WIDTH-1:0] i_pc,
  input  logic [INS_WIDTH-1:0] i_ins,
  input  logic                 i_flush,
  output logic                 o_post_valid,
  input  logic                 i_post_ready,
  output logic [CPU_WIDTH-1:0] o_pc,
  output logic [INS_WIDTH-1:0] o_ins,
`ifdef IFU_IDU_BUF_PERF_EN
  output logic [31:0]          o_stall_cnt,
  output logic [31:0]          o_bubble_cnt,
`endif
  output logic [1:0]           o_cnt
);

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  logic [1:0]           cnt;
  logic [CPU_WIDTH-1:0] head_pc;
  logic [INS_WIDTH-1:0] head_ins;
  logic [CPU_WIDTH-1:0] tail_pc;
  logic [INS_WIDTH-1:0] tail_ins;
  logic                 push;
  logic                 pop;

  assign o_pre_ready  = (cnt != CNT_FULL);
  assign o_post_valid = (cnt != CNT_EMPTY);
  assign o_cnt        = cnt;
  assign o_pc         = head_pc;
  assign o_ins        = head_ins;

  assign push = i_pre_valid && o_pre_ready;
  assign pop  = o_post_valid && i_post_ready;

  // Head registers drive the outputs directly; the tail slot only shifts into head.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt      <= CNT_EMPTY;
      head_pc  <= '0;
      head_ins <= '0;
    end else if (i_flush) begin
      cnt <= CNT_EMPTY;
    end else begin
      case (cnt)
        CNT_EMPTY: begin
          if (push) begin
            head_pc  <= i_pc;
            head_ins <= i_ins;
            cnt      <= CNT_ONE;
          end
        end
        CNT_ONE: begin
          if (push && pop) begin
            head_pc  <= i_pc;
            head_ins <= i_ins;
          end else if (push) begin
            cnt <= CNT_FULL;
          end else if (pop) begin
            cnt <= CNT_EMPTY;
          end
        end
        CNT_FULL: begin
          if (pop) begin
            head_pc  <= tail_pc;
            head_ins <= tail_ins;
            cnt      <= CNT_ONE;
          end
        end
        default: cnt <= CNT_EMPTY;
      endcase
    end
  end

  // Tail is only meaningful when cnt==2, so it is written on every push without reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      tail_pc  <= i_pc;
      tail_ins <= i_ins;
    end
  end

`ifdef IFU_IDU_BUF_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (i_pre_valid && !o_pre_ready && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (i_post_ready && !o_post_valid && (bubble_cnt != 32'hFFFF_FFFF))
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign o_stall_cnt  = stall_cnt;
  assign o_bubble_cnt = bubble_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifu_idu_buf.sv
// tb_ifu_idu_buf: directed plus randomized checks of ifu_idu_buf against a queue model.
`default_nettype none

module tb_ifu_idu_buf;

  logic        clk = 1'b0;
  logic        rst, pre_valid, flush, post_ready;
  logic [31:0] pc, ins;
  wire         pre_ready, post_valid;
  wire  [31:0] out_pc, out_ins;
  wire  [1:0]  cnt;
`ifdef IFU_IDU_BUF_PERF_EN
  wire  [31:0] stall_cnt, bubble_cnt;
`endif

  always #5 clk = ~clk;

  ifu_idu_buf #(.CPU_WIDTH(32), .INS_WIDTH(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pre_valid  (pre_valid),
    .o_pre_ready  (pre_ready),
    .i_pc         (pc),
    .i_ins        (ins),
    .i_flush      (flush),
    .o_post_valid (post_valid),
    .i_post_ready (post_ready),
    .o_pc         (out_pc),
    .o_ins        (out_ins),
`ifdef IFU_IDU_BUF_PERF_EN
    .o_stall_cnt  (stall_cnt),
    .o_bubble_cnt (bubble_cnt),
`endif
    .o_cnt        (cnt)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] q[$];
  logic [63:0] last_head = '0;
  logic [31:0] stall_m = '0;
  logic [31:0] bubble_m = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [63:0] h;
    h = (q.size() != 0) ? q[0] : last_head;
    check("cnt",        {30'd0, cnt},        q.size());
    check("post_valid", {31'd0, post_valid}, {31'd0, q.size() != 0});
    check("pre_ready",  {31'd0, pre_ready},  {31'd0, q.size() != 2});
    check("pc",         out_pc,              h[63:32]);
    check("ins",        out_ins,             h[31:0]);
`ifdef IFU_IDU_BUF_PERF_EN
    check("stall_cnt",  stall_cnt,           stall_m);
    check("bubble_cnt", bubble_cnt,          bubble_m);
`endif
  endtask

  // Behavioural model: a FIFO of at most two {pc,ins} pairs.
  task automatic model_update();
    bit do_push, do_pop;
    if (rst) begin
      q.delete();
      last_head = '0;
      stall_m   = '0;
      bubble_m  = '0;
      return;
    end
    if (pre_valid && q.size() == 2 && stall_m != 32'hFFFF_FFFF) stall_m++;
    if (post_ready && q.size() == 0 && bubble_m != 32'hFFFF_FFFF) bubble_m++;
    do_push = pre_valid && (q.size() < 2);
    do_pop  = post_ready && (q.size() > 0);
    if (flush) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({pc, ins});
    end
    if (q.size() != 0) last_head = q[0];
  endtask

  task automatic step(input bit r, input bit pv, input logic [31:0] p, input logic [31:0] i,
                      input bit pr, input bit fl, input bit chk);
    @(negedge clk);
    if (chk) check_outputs();
    rst = r; pre_valid = pv; pc = p; ins = i; post_ready = pr; flush = fl;
    @(posedge clk);
    model_update();
  endtask

  initial begin
    bit          pend;
    bit          pv, pr, fl, r, acc;
    logic [31:0] rp, ri;

    rst = 1'b1; pre_valid = 1'b0; flush = 1'b0; post_ready = 1'b0; pc = '0; ins = '0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h8000_0000, 32'h0000_0413, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);

    // Fill with decode stalled, hold the third push, then drain in order
    step(0, 1, 32'h8000_0000, 32'h1111_0001, 0, 0, 1);
    step(0, 1, 32'h8000_0004, 32'h1111_0002, 0, 0, 1);
    for (int k = 0; k < 3; k++) step(0, 1, 32'h8000_0008, 32'h1111_0003, 0, 0, 1);
    step(0, 1, 32'h8000_0008, 32'h1111_0003, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);

    for (int k = 0; k < 16; k++)
      step(0, 1, 32'h8000_0200 + 32'(4 * k), 32'hA000_0000 + 32'(k), 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);

    // Flush while full with a concurrent push that must be discarded
    step(0, 1, 32'h8000_0010, 32'h2222_0001, 0, 0, 1);
    step(0, 1, 32'h8000_0014, 32'h2222_0002, 0, 0, 1);
    step(0, 1, 32'h8000_0100, 32'h2222_0100, 0, 1, 1);
    step(0, 1, 32'h8000_0100, 32'h2222_0100, 0, 1, 1);
    step(0, 1, 32'h8000_0300, 32'h2222_0300, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);

    // Reset dominates a simultaneous flush while full
    step(0, 1, 32'h8000_0020, 32'h3333_0001, 0, 0, 1);
    step(0, 1, 32'h8000_0024, 32'h3333_0002, 0, 0, 1);
    step(1, 1, 32'h8000_0028, 32'h3333_0003, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    check("rst_pc_zero", out_pc, 32'h0);

    // Performance counter scenario: 5 stalled cycles then 3 bubble cycles
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 32'h8000_0040, 32'h4444_0001, 0, 0, 1);
    step(0, 1, 32'h8000_0044, 32'h4444_0002, 0, 0, 1);
    for (int k = 0; k < 5; k++) step(0, 1, 32'h8000_0048, 32'h4444_0003, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
`ifdef IFU_IDU_BUF_PERF_EN
    check("stall_five",   stall_cnt,  32'd5);
    check("bubble_three", bubble_cnt, 32'd3);
`endif

    // Randomized traffic; fetch holds pc/ins until its push is accepted
    pend = 1'b0; rp = '0; ri = '0;
    for (int k = 0; k < 400; k++) begin
      r  = ($urandom_range(0, 99) == 0);
      fl = ($urandom_range(0, 15) == 0);
      pr = ($urandom_range(0, 2) != 0);
      if (!pend) begin
        pv = ($urandom_range(0, 3) != 0);
        rp = $urandom;
        ri = $urandom;
      end else begin
        pv = 1'b1;
      end
      acc  = pv && (q.size() < 2);
      step(r, pv, rp, ri, pr, fl, 1);
      pend = pv && !acc && !r;
    end
    step(0, 0, 0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
